// File: rtl/shift_arb_4_pkg.sv
// Shared definitions for the shift arbiter: core count, shifter latency,
// the response tag record and small bit-manipulation helpers.
package shift_arb_4_pkg;

    localparam int NREQ = 4;
    localparam int LAT  = 7;
    localparam int DW   = 64;

    // One entry of the response tag pipeline.
    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } tag_t;

    // Number of set bits in a 4-bit vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Core index to one-hot strobe.
    function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/shift_arb_4_if.sv
// Request / shifter / response bundle between the cores, the arbiter and
// the external pipelined shifter.
interface shift_arb_4_if;
    import shift_arb_4_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [64*NREQ-1:0]   req_a;
    logic [64*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic [63:0]          sh_a;
    logic [63:0]          sh_b;
    logic [63:0]          sh_out;
    logic [NREQ-1:0]      resp_valid;
    logic [63:0]          resp_data;
    logic [2:0]           inflight;

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, sh_out,
        output req_ready, sh_a, sh_b, resp_valid, resp_data, inflight
    );

    // Core / shifter side.
    modport master (
        output req_valid, req_a, req_b, sh_out,
        input  req_ready, sh_a, sh_b, resp_valid, resp_data, inflight
    );

endinterface

// File: rtl/shift_arb_4_rr_arb.sv
// Combinational round-robin grant over four eligible cores, searching
// from the priority pointer upward with wrap-around.
module rr_arb_4 (
    input  logic [3:0] eligible_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] grant_o,
    output logic [1:0] gnt_id_o,
    output logic       gnt_valid_o
);

    logic [1:0] idx_s;
    logic       found_s;

    // First eligible core at or after the pointer wins.
    always_comb begin
        grant_o  = 4'b0000;
        gnt_id_o = 2'd0;
        found_s  = 1'b0;
        idx_s    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx_s = ptr_i + 2'(k);
            if (!found_s && eligible_i[idx_s]) begin
                found_s  = 1'b1;
                gnt_id_o = idx_s;
                grant_o  = 4'b0001 << idx_s;
            end else begin
                found_s  = found_s;
            end
        end
        gnt_valid_o = found_s;
    end

endmodule

// File: rtl/shift_arb_4.sv
// Shares one external pipelined 64-bit right shifter among four cores.
// Each core may have one operation outstanding; results are routed back
// to the issuing core by a tag pipeline matching the shifter latency.
module shift_arb_4 #(
    parameter int NREQ = shift_arb_4_pkg::NREQ,
    parameter int LAT  = shift_arb_4_pkg::LAT
) (
    input  logic          clk,
    input  logic          rst,
    shift_arb_4_if.slave  bus
);
    import shift_arb_4_pkg::*;

    logic [NREQ-1:0] pending_q;
    logic [NREQ-1:0] pending_d;
    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] resp_valid_s;
    logic [1:0]      ptr_q;
    logic [1:0]      ptr_d;
    logic [1:0]      gnt_id_s;
    logic            gnt_valid_s;
    tag_t            tag_q [LAT];
    tag_t            last_s;

    // A core competes only when it asks and has nothing outstanding; reset masks everything.
    always_comb begin
        if (rst) begin
            eligible_s = 4'b0000;
        end else begin
            eligible_s = bus.req_valid & ~pending_q;
        end
    end

    rr_arb_4 u_rr (
        .eligible_i  (eligible_s),
        .ptr_i       (ptr_q),
        .grant_o     (grant_s),
        .gnt_id_o    (gnt_id_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Grant is the ready strobe; the granted operands go straight to the shifter.
    always_comb begin
        bus.req_ready = grant_s;
        if (gnt_valid_s) begin
            bus.sh_a = bus.req_a[{gnt_id_s, 6'b000000} +: 64];
            bus.sh_b = bus.req_b[{gnt_id_s, 6'b000000} +: 64];
        end else begin
            bus.sh_a = 64'd0;
            bus.sh_b = 64'd0;
        end
    end

    // The oldest tag stage lines up with the shifter output and selects the owner.
    always_comb begin
        last_s = tag_q[LAT-1];
        if (last_s.valid && !rst) begin
            resp_valid_s  = id_to_onehot(last_s.id);
            bus.resp_data = bus.sh_out;
        end else begin
            resp_valid_s  = 4'b0000;
            bus.resp_data = 64'd0;
        end
        bus.resp_valid = resp_valid_s;
    end

    // Next pending set and pointer; a core's bit drops after its response cycle.
    always_comb begin
        pending_d = (pending_q | grant_s) & ~resp_valid_s;
        if (gnt_valid_s) begin
            ptr_d = gnt_id_s + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Outstanding count is one per pending core.
    always_comb begin
        if (rst) begin
            bus.inflight = 3'd0;
        end else begin
            bus.inflight = popcount4(pending_q);
        end
    end

    // State update: pointer, pending set and the tag shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= 2'd0;
            pending_q <= 4'b0000;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= tag_t'(3'b000);
            end
        end else begin
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            tag_q[0]  <= '{valid: gnt_valid_s, id: gnt_id_s};
            for (int k = 1; k < LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

endmodule
